// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore sequencing controller for the multi-cycle MIPS
// datapath. Walks FETCH/DECODE and per-instruction states, driving every
// datapath select and write enable. It stalls on mem_ready in the memory
// states, pulses instr_done in the last cycle of an instruction and flags
// unsupported opcodes in DECODE.
// Optional feature: define MC_CTRL_JUMP_EN to decode J (000010) through JMP_DONE.
module multicycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ALUSrcB,
    output logic [STATE_W-1:0] state,
    output logic               instr_done,
    output logic               illegal_op
);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
`ifdef MC_CTRL_JUMP_EN
    localparam logic [5:0] OP_J   = 6'b000010;
`endif

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_DONE   = 4'd7,
        BR_DONE  = 4'd8
`ifdef MC_CTRL_JUMP_EN
        ,
        JMP_DONE = 4'd9
`endif
    } state_t;

    state_t currState;
    state_t nextState;

    // State register; reset always lands in FETCH so any in-flight instruction is abandoned
    always_ff @(posedge clk) begin
        if (reset) begin
            currState <= FETCH;
        end else begin
            currState <= nextState;
        end
    end

    // Next-state and Moore outputs; reset overrides every output to 0 so no write fires while it is high
    always_comb begin
        nextState   = currState;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        state       = STATE_W'(currState);

        case (currState)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    nextState = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nextState = MEM_ADDR;
                    OP_R:         nextState = EXEC;
                    OP_BEQ:       nextState = BR_DONE;
`ifdef MC_CTRL_JUMP_EN
                    OP_J:         nextState = JMP_DONE;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        nextState  = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nextState = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    nextState = MEM_WB;
                end
            end
            MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                nextState  = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end
            end
            EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                nextState = R_DONE;
            end
            R_DONE: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                nextState  = FETCH;
            end
            BR_DONE: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                nextState   = FETCH;
            end
`ifdef MC_CTRL_JUMP_EN
            JMP_DONE: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                nextState  = FETCH;
            end
`endif
            default: nextState = FETCH;
        endcase

        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            ALUSrcA     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            PCSource    = 2'b00;
            ALUOp       = 2'b00;
            ALUSrcB     = 2'b00;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
            state       = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed plus randomised instruction streams for
// multicycle_control_fsm. Each instruction is expanded into its expected
// per-cycle state list from the opcode and the chosen wait counts, and each
// cycle's outputs are compared against the control word that state calls for.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         st;
        bit         rdy;
        bit         rst;
        logic [5:0] op;
    } step_t;

    step_t q[$];

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isLegal(input logic [5:0] op);
        if (op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100) return 1'b1;
`ifdef MC_CTRL_JUMP_EN
        if (op == 6'b000010) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Expected control word {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
    // MemtoReg,ALUSrcA,RegWrite,RegDst,PCSource,ALUOp,ALUSrcB,instr_done,illegal_op}
    function automatic logic [17:0] expCtrl(input step_t s);
        logic [17:0] v;
        v = '0;
        if (s.rst) return v;
        case (s.st)
            0: begin v[14] = 1'b1; v[3:2] = 2'b01; v[17] = s.rdy; v[12] = s.rdy; end
            1: begin v[3:2] = 2'b11; v[0] = !isLegal(s.op); end
            2: begin v[10] = 1'b1; v[3:2] = 2'b10; end
            3: begin v[14] = 1'b1; v[15] = 1'b1; end
            4: begin v[9] = 1'b1; v[11] = 1'b1; v[1] = 1'b1; end
            5: begin v[13] = 1'b1; v[15] = 1'b1; v[1] = s.rdy; end
            6: begin v[10] = 1'b1; v[5:4] = 2'b10; end
            7: begin v[9] = 1'b1; v[8] = 1'b1; v[1] = 1'b1; end
            8: begin v[10] = 1'b1; v[5:4] = 2'b01; v[16] = 1'b1; v[7:6] = 2'b01; v[1] = 1'b1; end
            9: begin v[17] = 1'b1; v[7:6] = 2'b10; v[1] = 1'b1; end
            default: v = '1;
        endcase
        return v;
    endfunction

    task automatic pushStep(input int st, input bit rdy, input bit rst, input logic [5:0] op);
        step_t s;
        s.st = st; s.rdy = rdy; s.rst = rst; s.op = op;
        q.push_back(s);
    endtask

    // Memory-style state: waits cycles with ready low, then one with ready high
    task automatic pushMem(input int st, input int waits, input logic [5:0] op);
        for (int i = 0; i < waits; i++) pushStep(st, 1'b0, 1'b0, op);
        pushStep(st, 1'b1, 1'b0, op);
    endtask

    // Expand one instruction into its expected state walk
    task automatic buildInstr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) pushStep(0, 1'b0, 1'b0, 6'($urandom));
        pushStep(0, 1'b1, 1'b0, 6'($urandom));
        pushStep(1, 1'($urandom), 1'b0, op);
        if (!isLegal(op)) return;
        case (op)
            6'b100011: begin
                pushStep(2, 1'($urandom), 1'b0, op);
                pushMem(3, mw, op);
                pushStep(4, 1'($urandom), 1'b0, op);
            end
            6'b101011: begin
                pushStep(2, 1'($urandom), 1'b0, op);
                pushMem(5, mw, op);
            end
            6'b000000: begin
                pushStep(6, 1'($urandom), 1'b0, op);
                pushStep(7, 1'($urandom), 1'b0, op);
            end
            6'b000100: pushStep(8, 1'($urandom), 1'b0, op);
            default:   pushStep(9, 1'($urandom), 1'b0, op);
        endcase
    endtask

    task automatic checkOutput(input step_t s);
        logic [17:0] obs, exp;
        obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, instr_done, illegal_op};
        exp = expCtrl(s);
        checks++;
        assert (state === 4'(s.st))
        else begin
            failures++;
            $error("[TB] FAIL state: got %0d expected %0d", state, s.st);
        end
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL ctrl(state %0d rdy %0b rst %0b op %b): got %b expected %b",
                   s.st, s.rdy, s.rst, s.op, obs, exp);
        end
        checks++;
        assert ((MemRead & MemWrite) === 1'b0)
        else begin
            failures++;
            $error("[TB] FAIL mem_excl: MemRead=%b MemWrite=%b expected not both 1", MemRead, MemWrite);
        end
    endtask

    // Drive one cycle's inputs after the edge, check mid-cycle, advance past next edge
    task automatic applyStimulus(input step_t s);
        reset     = s.rst;
        mem_ready = s.rdy;
        opcode    = s.op;
        @(negedge clk);
        checkOutput(s);
        @(posedge clk);
        #1;
    endtask

    task automatic runQueue();
        while (q.size() > 0) applyStimulus(q.pop_front());
    endtask

    // Keep only steps 0..k, then hit the controller with one reset cycle
    task automatic abortAt(input int k);
        q = q[0:k];
        pushStep(0, 1'($urandom), 1'b1, 6'($urandom));
    endtask

    initial begin
        int idx;
        int r;
        logic [5:0] op;
        reset = 1'b1; mem_ready = 1'b1; opcode = '0;

        // Reset held three cycles with mem_ready high
        for (int i = 0; i < 3; i++) pushStep(0, 1'b1, 1'b1, 6'b000000);
        runQueue();

        // Directed: R, LW with two MEM_RD stalls, SW, BEQ, 000010
        buildInstr(6'b000000, 0, 0); runQueue();
        buildInstr(6'b100011, 0, 2); runQueue();
        buildInstr(6'b101011, 0, 0); runQueue();
        buildInstr(6'b000100, 0, 0); runQueue();
        buildInstr(6'b000010, 0, 0); runQueue();
        buildInstr(6'b111111, 2, 0); runQueue();

        // Directed: reset while stalled in MEM_WR
        buildInstr(6'b101011, 1, 3);
        idx = 0;
        while (q[idx].st != 5) idx++;
        abortAt(idx);
        runQueue();
        buildInstr(6'b000000, 0, 0); runQueue();

        // Randomised instruction stream with occasional mid-instruction resets
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            buildInstr(op, $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) abortAt($urandom_range(0, q.size() - 1));
            runQueue();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

- Sequencing controller for the multi-cycle MIPS datapath: one shared memory, one ALU, one IR; each instruction takes 3–5 states instead of one cycle.
- Decodes the 6-bit opcode from the instruction register and walks a Moore state machine that drives every datapath mux select and write enable.
- Stalls in memory states on a ready handshake and reports instruction retirement and illegal opcodes.

## Interface
- STATE_W, 4, width of the exported state register.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26]; valid from DECODE onward (IR is frozen while IRWrite=0).
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  output  1 each  datapath enables/selects.
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp  output  2  00 add, 01 subtract, 10 funct-decoded.
- ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- state  output  STATE_W  current state code, for debug.
- instr_done  output  1  one-cycle pulse in the last cycle of an instruction.
- illegal_op  output  1  high in DECODE when opcode is unsupported.

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_DONE=7, BR_DONE=8, JMP_DONE=9.
- Supported opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010 (J only with macro).
- Every output not listed for a state is 0. No output is ever driven x.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch-target precompute).
  - Next state by opcode: LW/SW→MEM_ADDR, R→EXEC, BEQ→BR_DONE, J→JMP_DONE.
  - Any other opcode: illegal_op=1, next state FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: MemRead=1, IorD=1. Stay while mem_ready=0, else go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next state FETCH.
- MEM_WR: MemWrite=1, IorD=1. Stay while mem_ready=0.
  - When mem_ready=1: instr_done=1, next state FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state R_DONE.
- R_DONE: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next state FETCH.
- BR_DONE: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next state FETCH.
- JMP_DONE: PCWrite=1, PCSource=10, instr_done=1. Next state FETCH.
- MemRead and MemWrite are never both 1. Only one memory access is outstanding at a time.

## Timing
- Outputs are combinational from the state register plus mem_ready (FETCH and MEM_WR only). State updates on the rising clk edge.
- Zero-wait latency in cycles: R 4, LW 5, SW 4, BEQ 3, J 3, illegal 2. Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one.
- Reset:
  - While reset=1, every output is forced to 0, including illegal_op and instr_done.
  - On the first edge with reset high, state=FETCH.
  - After the first edge with reset low, FETCH begins issuing reads.
- Reset mid-instruction (including during a wait state) abandons the instruction. No write enable is asserted during the reset cycle.
- mem_ready is ignored in states that do not access memory.

## Configuration
- MC_CTRL_JUMP_EN defined:
  - J (000010) decodes to JMP_DONE.
  - PCSource=10 is reachable.
- MC_CTRL_JUMP_EN undefined:
  - JMP_DONE is not built.
  - 000010 is illegal: illegal_op=1, return to FETCH.
  - PCSource never exceeds 01.

## Test plan
- Reset held 3 cycles, mem_ready=1 → all outputs 0 during reset. First cycle after release: state=0, MemRead=1, IRWrite=1, PCWrite=1.
- R-type (000000), mem_ready=1 → state sequence 0,1,6,7,0. R_DONE shows RegWrite=1, RegDst=1, instr_done=1 for exactly one cycle.
- LW (100011) with mem_ready low for 2 cycles in MEM_RD → sequence 0,1,2,3,3,3,4,0. MemRead=1, IorD=1 throughout MEM_RD. RegWrite=1, MemtoReg=1 in MEM_WB only.
- SW (101011) followed by BEQ (000100), mem_ready=1 →
  - SW: 0,1,2,5,0 with MemWrite=1 for one cycle.
  - BEQ: 0,1,8,0 with PCWriteCond=1, ALUOp=01, PCSource=01.
- Opcode 000010:
  - With MC_CTRL_JUMP_EN: 0,1,9,0 with PCWrite=1, PCSource=10.
  - Without it: 0,1,0 with illegal_op=1 in DECODE and instr_done never asserted.
- Reset asserted while in MEM_WR with mem_ready=0 → MemWrite drops to 0 that cycle and state=0 on the next edge. Randomised runs check MemRead & MemWrite is never 1.
